// File: rtl/cmp_field.sv
// Sign-magnitude field comparator: compares a byte range of two words,
// one byte per cycle from the most significant byte, with an optional sign.
module cmp_field #(
  parameter  int BYTE_W = 6,
  parameter  int BYTES  = 5,
  localparam int W      = 1 + BYTES * BYTE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   field,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         busy,
  output logic         stop,
  output logic         greater,
  output logic         less,
  output logic         equal,
  output logic         fault
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [2:0] NBYTES = 3'(BYTES);

  state_t              state;
  logic [W-1:0]        a_p0, b_p0;
  logic [2:0]          l_p0, r_p0, idx;
  logic [2:0]          fl, fr;
  logic                field_bad;
  logic [BYTE_W-1:0]   ba, bb;
  logic [2:0]          res;

  // Byte 1 sits just below the sign bit, byte BYTES at the LSBs.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [W-1:0] w, input logic [2:0] i);
    byte_sel = '0;
    for (int j = 1; j <= BYTES; j++)
      if (i == 3'(j)) byte_sel = w[(BYTES-j)*BYTE_W +: BYTE_W];
  endfunction

  // Returns {greater, less, equal}; equal magnitudes compare equal whatever the signs.
  function automatic logic [2:0] resolve(input logic gt, input logic lt, input logic sa,
                                         input logic sb, input logic use_sign);
    logic g;
    if (!gt && !lt) begin
      resolve = 3'b001;
    end else begin
      g = gt;
      if (use_sign && (sa != sb)) g = !sa;
      else if (use_sign && sa)    g = !gt;
      resolve = {g, !g, 1'b0};
    end
  endfunction

  assign fl        = field[5:3];
  assign fr        = field[2:0];
  assign field_bad = (fl > fr) || (fr > NBYTES);

  assign ba  = byte_sel(a_p0, idx);
  assign bb  = byte_sel(b_p0, idx);
  assign res = resolve(ba > bb, ba < bb, a_p0[W-1], b_p0[W-1], l_p0 == 3'd0);

  // Stage p0: operands and field captured on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_p0 <= in1;
      b_p0 <= in2;
      l_p0 <= fl;
      r_p0 <= fr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      stop    <= 1'b0;
      fault   <= 1'b0;
      greater <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b1;
      idx     <= '0;
    end else begin
      stop  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (field_bad) begin
              stop  <= 1'b1;
              fault <= 1'b1;
            end else if (fr == 3'd0) begin
              stop                   <= 1'b1;
              {greater, less, equal} <= 3'b001;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
              idx   <= (fl == 3'd0) ? 3'd1 : fl;
            end
          end
        end
        SCAN: begin
          if (ba != bb || idx == r_p0) begin
            state                  <= IDLE;
            busy                   <= 1'b0;
            stop                   <= 1'b1;
            {greater, less, equal} <= res;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmp_field.md
CMP_FIELD -- requirements
Module: cmp_field

Interface
REQ-001 Parameter BYTE_W, default 6, bits per byte.
REQ-002 Parameter BYTES, default 5, magnitude bytes per word; legal range 1..7.
REQ-003 Local W = 1+BYTES*BYTE_W; sign at bit W-1 (1 = negative); byte 1 (most significant) directly below the sign, byte BYTES at LSBs.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a comparison; sampled only when busy=0.
REQ-007 field  input  6  field spec; L=field[5:3], R=field[2:0]; sampled with start.
REQ-008 in1  input  W  operand A (sign-magnitude); sampled with start.
REQ-009 in2  input  W  operand B (sign-magnitude); sampled with start.
REQ-010 busy  output  1  scan in progress.
REQ-011 stop  output  1  one-cycle completion pulse.
REQ-012 greater / less / equal  output  1 each  comparison indicator, exactly one high at all times.
REQ-013 fault  output  1  invalid field; valid only while stop=1.

Function
REQ-014 Operands, L and R SHALL be registered on the accepting edge; later input changes are ignored.
REQ-015 Field invalid when L>R or R>BYTES: no scan, stop=fault=1 one cycle after start, indicators unchanged.
REQ-016 Sign participation: L=0 uses the operand signs; L>=1 treats both operands as positive.
REQ-017 Scan range: bytes max(L,1)..R, most significant first, one byte per cycle; L=R=0 scans zero bytes.
REQ-018 FSM states: IDLE, SCAN. IDLE->SCAN on accepted start with valid field and R>=1; otherwise IDLE->IDLE with the completion pulse.
REQ-019 SCAN leaves to IDLE on the first unequal byte, or after byte R; k = number of bytes compared (0..BYTES).
REQ-020 Latency: stop high exactly k+1 cycles after the start cycle; indicators take the new value in that same cycle.
REQ-021 busy SHALL be high from the cycle after start through the last SCAN cycle, and low in the stop cycle.
REQ-022 A start in the stop cycle SHALL be accepted (back-to-back).
REQ-023 A start while busy=1 SHALL be ignored with no effect.
REQ-024 Magnitude order is decided by the first unequal byte, compared as unsigned; magnitude equal if no byte differs.
REQ-025 Magnitude equal SHALL give equal regardless of signs (+0 equals -0).
REQ-026 Signs differ with nonzero magnitude: the positive operand is greater.
REQ-027 Both positive: result follows magnitude order; both negative: magnitude order inverted.
REQ-028 Indicators and fault SHALL hold until the next completion or reset; fault SHALL be 0 whenever stop=0.

Reset
REQ-029 reset SHALL force IDLE, busy=0, stop=0, fault=0, equal=1, greater=0, less=0 on the next edge.
REQ-030 reset during SCAN SHALL abort the comparison with no stop pulse; reset has priority over start in the same cycle.

Verification
(BYTE_W=6, BYTES=5.)
REQ-031 in1=+5, in2=+3, field=(0:5) -> k=5; stop and greater=1 six cycles after start; busy high five cycles.
REQ-032 in1=-0, in2=+0, field=(0:5) -> equal=1 after 6 cycles, fault=0.
REQ-033 in1=-(byte1=2), in2=+(byte1=1) -> field (1:5) gives greater after 2 cycles; field (0:5) gives less after 2 cycles.
REQ-034 field=(0:0), in1=-7, in2=+9 -> equal=1; stop one cycle after start; busy never high.
REQ-035 field=(4:2) after a prior less result -> stop=fault=1 one cycle after start; less stays 1. Repeat with field=(0:6): same response.
REQ-036 reset on the 2nd SCAN cycle -> no stop; next cycle busy=0, equal=1. A start during busy is ignored; a start in the stop cycle returns stop again after k+1 cycles.
